tinker_fetch: RTL and testbench
===============================

Name: tinker_fetch

Overview:
- Instruction-fetch (IF) stage of the 5-stage tinker_core pipeline. It sits directly upstream of decode.
- Holds the fetch PC and issues 32-bit reads to the unified byte memory, which returns little-endian words (byte at addr is instr[7:0]).
- Buffers fetched words in a small prefetch FIFO and hands {pc, instr} to decode over a valid/ready handshake.
- Handles branch redirects, halt detection and misaligned-target faults.

Parameters:
- RESET_PC, 64'h0000_0000_0000_2000, first fetch address after reset (byte 8192).
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- HALT_OPCODE, 5'h0F, opcode of the halt instruction (instr[31:27]); halt also requires instr[11:0] == 0.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_rd_en  output  1  read request this cycle.
- mem_rd_addr  output  64  byte address of the request, always 4-aligned.
- mem_rd_data  input  32  read data, valid exactly 1 cycle after the request.
- redirect_valid  input  1  branch/jump resolved taken; flush and refetch.
- redirect_pc  input  64  new fetch target.
- id_ready  input  1  decode can accept an instruction.
- if_valid  output  1  {if_pc, if_instr} valid for decode.
- if_instr  output  32  instruction word at FIFO head.
- if_pc  output  64  address of if_instr.
- halted  output  1  halt word enqueued; fetching stopped.
- fetch_fault  output  1  sticky misaligned-redirect fault.

Behaviour:
- Reset (reset == 0, asynchronous):
  - fetch_pc = RESET_PC; FIFO empty; no read in flight.
  - halted = 0, fetch_fault = 0, if_valid = 0, if_instr = 0, if_pc = 0.
  - mem_rd_en = 0, mem_rd_addr = RESET_PC.
- Issue rule:
  - mem_rd_en = !halted && !fetch_fault && !redirect_valid && (count + inflight) < DEPTH.
  - mem_rd_addr = fetch_pc.
  - On issue: fetch_pc += 4, mod 2^64 (wraps silently).
  - At most one read is in flight.
- Response:
  - The cycle after an issue, mem_rd_data is written to the FIFO tail with its pc, unless that read was squashed.
  - Squash is tracked with an epoch bit captured at issue and compared at response.
- Latency:
  - First mem_rd_en is in the first cycle after reset deasserts.
  - if_valid rises 2 cycles after an issue into an empty FIFO.
  - Steady-state throughput with id_ready = 1 is 1 instruction/cycle once the FIFO holds >= 1 entry.
- Handshake:
  - Transfer occurs on an edge where if_valid && id_ready; the head is popped.
  - if_valid, if_instr and if_pc are driven from the registered FIFO head (no combinational path from id_ready).
  - Head contents are stable while if_valid && !id_ready.
- Full / empty:
  - Enqueue and dequeue in the same cycle keep count unchanged.
  - Reads are never issued when no slot is reserved for them, so a response is never dropped for lack of space.
- Redirect (priority over everything except reset), in cycle T:
  - FIFO cleared; epoch toggled, so the response arriving at T+1 is discarded.
  - fetch_pc = redirect_pc; halted cleared.
  - No issue in cycle T; the first issue of redirect_pc is at T+1.
  - A decode handshake coinciding with a redirect is legal; the entry is dropped regardless.
- Misaligned redirect (redirect_pc[1:0] != 0):
  - fetch_fault set; FIFO flushed; issue stops.
  - Cleared only by a later aligned redirect or by reset.
- Halt:
  - When a non-squashed response has instr[31:27] == HALT_OPCODE and instr[11:0] == 0, the word is enqueued normally and halted is set at that edge.
  - Any response already in flight is discarded; no further issues.
  - The halt word is still delivered to decode.
- Reset asserted mid-operation: all state returns to reset values immediately; pending data is lost.

Optional Feature:
- Macro: TINKER_FETCH_PERF_EN.
- When defined, add output ports perf_fetched [31:0] and perf_squashed [31:0]:
  - perf_fetched counts words enqueued.
  - perf_squashed counts FIFO entries flushed plus in-flight responses discarded.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Sequential fetch: mem[8192] = 32'h00211000 (AND r0, r16, r17), mem[8196] = 32'h11000000; release reset with id_ready = 1 -> decode receives pc 0x2000 / 0x00211000, then pc 0x2004 / 0x11000000, consecutive and in order.
- Backpressure: id_ready = 0 for 10 cycles -> FIFO fills to DEPTH = 4 and mem_rd_en drops; after id_ready = 1, pcs 0x2000..0x200C are delivered with no loss or duplicates.
- Redirect: with FIFO full and a read in flight, pulse redirect_valid with redirect_pc = 0x3000 -> next delivered pc is 0x3000 and no 0x20xx word appears afterwards.
- Halt: mem[0x2008] = 32'h78000000 -> halted = 1 the edge it is enqueued; 0x2008 is delivered, 0x200C never is, mem_rd_en stays 0; a redirect to 0x2000 resumes fetch.
- Fault: redirect_pc = 0x3002 -> fetch_fault = 1 and no mem_rd_en; a redirect to 0x3004 clears it and fetch resumes.
- Async reset: drop reset mid-stream between clock edges -> all outputs reach reset values before the next edge; after release, fetch restarts at 0x2000.

Source files
------------

// File: rtl/tinker_fetch.sv
// tinker_fetch: instruction-fetch stage with a prefetch FIFO, redirect/epoch squash, halt and fault handling.
// Define TINKER_FETCH_PERF_EN to add the perf_fetched / perf_squashed saturating counters.
module tinker_fetch #(
   parameter logic [63:0] RESET_PC    = 64'h0000_0000_0000_2000,
   parameter int          DEPTH       = 4,
   parameter logic [4:0]  HALT_OPCODE = 5'h0F
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_rd_en,
   output logic [63:0] mem_rd_addr,
   input  logic [31:0] mem_rd_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [63:0] if_pc,
   output logic        halted,
   output logic        fetch_fault
`ifdef TINKER_FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_squashed
`endif
);

   localparam int                 PTR_W   = $clog2(DEPTH);
   localparam int                 CNT_W   = PTR_W + 1;
   localparam logic [CNT_W:0]     DEPTH_C = (CNT_W + 1)'(DEPTH);

   logic [63:0]      fetch_pc;
   logic             epoch;
   logic             vld_p1;
   logic             epoch_p1;
   logic [63:0]      pc_p1;
   logic [31:0]      instr_q [DEPTH];
   logic [63:0]      pc_q    [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   occupancy;
   logic             resp_live;
   logic             enq;
   logic             deq;
   logic             is_halt;

   // Slots already holding data plus the one reserved by a read in flight.
   assign occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1};
   assign mem_rd_en   = reset && !halted && !fetch_fault && !redirect_valid && (occupancy < DEPTH_C);
   assign mem_rd_addr = fetch_pc;

   assign resp_live = vld_p1 && (epoch_p1 == epoch);
   assign enq       = resp_live && !redirect_valid;
   assign deq       = if_valid && id_ready && !redirect_valid;
   assign is_halt   = (mem_rd_data[31:27] == HALT_OPCODE) && (mem_rd_data[11:0] == 12'h000);

   assign if_valid = (count != '0);
   assign if_instr = if_valid ? instr_q[rd_ptr] : 32'h0;
   assign if_pc    = if_valid ? pc_q[rd_ptr]    : 64'h0;

   // p0 -> p1: issue a read, response arrives one cycle later
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc    <= RESET_PC;
         epoch       <= 1'b0;
         vld_p1      <= 1'b0;
         epoch_p1    <= 1'b0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         halted      <= 1'b0;
         fetch_fault <= 1'b0;
      end else if (redirect_valid) begin
         fetch_pc    <= redirect_pc;
         epoch       <= ~epoch;
         vld_p1      <= 1'b0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         halted      <= 1'b0;
         fetch_fault <= (redirect_pc[1:0] != 2'b00);
      end else begin
         vld_p1   <= mem_rd_en;
         epoch_p1 <= epoch;
         if (mem_rd_en)
            fetch_pc <= fetch_pc + 64'd4;
         if (enq)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq)
            rd_ptr <= rd_ptr + PTR_W'(1);
         if (enq && !deq)
            count <= count + CNT_W'(1);
         else if (deq && !enq)
            count <= count - CNT_W'(1);
         // Flipping the epoch on halt squashes the read issued alongside the halt word.
         if (enq && is_halt) begin
            halted <= 1'b1;
            epoch  <= ~epoch;
         end
      end
   end

   // p1 -> FIFO: capture the response word with the pc it was fetched from
   always_ff @(posedge clk) begin
      if (mem_rd_en)
         pc_p1 <= fetch_pc;
      if (enq) begin
         instr_q[wr_ptr] <= mem_rd_data;
         pc_q[wr_ptr]    <= pc_p1;
      end
   end

`ifdef TINKER_FETCH_PERF_EN
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   logic [31:0] squash_now;

   always_comb begin
      squash_now = 32'h0;
      if (redirect_valid)
         squash_now = 32'(count) + 32'(vld_p1);
      else if (vld_p1 && !resp_live)
         squash_now = 32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_fetched  <= 32'h0;
         perf_squashed <= 32'h0;
      end else begin
         perf_fetched  <= sat_add(perf_fetched, {31'h0, enq});
         perf_squashed <= sat_add(perf_squashed, squash_now);
      end
   end
`endif

endmodule

// File: tb/tb_tinker_fetch.sv
// Self-checking bench for tinker_fetch: directed scenarios plus a randomized stream
// compared against a sequential-program reference model.
module tb_tinker_fetch;

   localparam logic [63:0] RESET_PC = 64'h0000_0000_0000_2000;
   localparam int          DEPTH    = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_rd_en;
   logic [63:0] mem_rd_addr;
   logic [31:0] mem_rd_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [63:0] if_pc;
   logic        halted;
   logic        fetch_fault;

   always #5 clk = ~clk;

   tinker_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .HALT_OPCODE(5'h0F)) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_rd_en      (mem_rd_en),
      .mem_rd_addr    (mem_rd_addr),
      .mem_rd_data    (mem_rd_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .halted         (halted),
      .fetch_fault    (fetch_fault)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [31:0] mem [logic [63:0]];
   logic [63:0] got_pc    [$];
   logic [31:0] got_instr [$];
   int          got_cyc   [$];
   logic [63:0] iss_addr  [$];
   int          iss_cyc   [$];

   // Unwritten words are random but never halt-shaped.
   function automatic logic [31:0] fetch_word(input logic [63:0] a);
      logic [31:0] w;
      if (!mem.exists(a)) begin
         w = $urandom;
         if (w[31:27] == 5'h0F)
            w[31] = 1'b0;
         mem[a] = w;
      end
      return mem[a];
   endfunction

   always @(posedge clk) begin
      if (mem_rd_en)
         mem_rd_data <= fetch_word(mem_rd_addr);
      else
         mem_rd_data <= 32'hDEAD_BEEF;
   end

   task automatic clear_obs();
      got_pc.delete();
      got_instr.delete();
      got_cyc.delete();
      iss_addr.delete();
      iss_cyc.delete();
   endtask

   // Record this cycle's handshake and issue, then advance to the next falling edge.
   task automatic tick();
      #1;
      if (if_valid && id_ready && !redirect_valid) begin
         got_pc.push_back(if_pc);
         got_instr.push_back(if_instr);
         got_cyc.push_back(cyc);
      end
      if (mem_rd_en) begin
         iss_addr.push_back(mem_rd_addr);
         iss_cyc.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      id_ready       = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      clear_obs();
      cyc = 0;
   endtask

   task automatic test_reset();
      reset          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      id_ready       = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if ({mem_rd_en, if_valid, halted, fetch_fault} !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_ctrl: en/valid/halted/fault=%b required 0000", {mem_rd_en, if_valid, halted, fetch_fault});
      end
      n_checks++;
      if (mem_rd_addr !== RESET_PC) begin
         n_errors++;
         $display("FAIL reset_addr: got %h required %h", mem_rd_addr, RESET_PC);
      end
      n_checks++;
      if (if_instr !== 32'h0 || if_pc !== 64'h0) begin
         n_errors++;
         $display("FAIL reset_head: instr=%h pc=%h required 0/0", if_instr, if_pc);
      end
      @(negedge clk);
      reset = 1'b1;
      clear_obs();
      cyc = 0;
      tick();
      n_checks++;
      if (iss_addr.size() != 1 || iss_cyc.size() != 1 || iss_addr[0] !== RESET_PC || iss_cyc[0] != 0) begin
         n_errors++;
         $display("FAIL first_issue: %0d issues in first cycle, required one at %h", iss_addr.size(), RESET_PC);
      end
   endtask

   task automatic test_sequential();
      mem.delete();
      mem[64'h2000] = 32'h0021_1000;
      mem[64'h2004] = 32'h1100_0000;
      apply_reset();
      id_ready = 1'b1;
      repeat (6) tick();
      n_checks++;
      if (got_pc.size() != 4) begin
         n_errors++;
         $display("FAIL seq_count: got %0d transfers required 4", got_pc.size());
      end
      if (got_pc.size() >= 2) begin
         n_checks++;
         if (got_pc[0] !== 64'h2000 || got_instr[0] !== 32'h0021_1000) begin
            n_errors++;
            $display("FAIL seq_first: pc=%h instr=%h required 2000/00211000", got_pc[0], got_instr[0]);
         end
         n_checks++;
         if (got_pc[1] !== 64'h2004 || got_instr[1] !== 32'h1100_0000) begin
            n_errors++;
            $display("FAIL seq_second: pc=%h instr=%h required 2004/11000000", got_pc[1], got_instr[1]);
         end
         n_checks++;
         if (got_cyc[0] != 2 || got_cyc[1] != 3) begin
            n_errors++;
            $display("FAIL seq_latency: cycles %0d,%0d required 2,3", got_cyc[0], got_cyc[1]);
         end
      end
   endtask

   task automatic test_backpressure();
      mem.delete();
      apply_reset();
      id_ready = 1'b0;
      repeat (10) tick();
      n_checks++;
      if (iss_addr.size() != DEPTH) begin
         n_errors++;
         $display("FAIL bp_issues: got %0d issues required %0d", iss_addr.size(), DEPTH);
      end
      #1;
      n_checks++;
      if (mem_rd_en !== 1'b0 || if_valid !== 1'b1 || if_pc !== 64'h2000) begin
         n_errors++;
         $display("FAIL bp_stall: en=%b valid=%b pc=%h required 0/1/2000", mem_rd_en, if_valid, if_pc);
      end
      clear_obs();
      id_ready = 1'b1;
      repeat (8) tick();
      n_checks++;
      if (got_pc.size() < DEPTH) begin
         n_errors++;
         $display("FAIL bp_drain: got %0d transfers required at least %0d", got_pc.size(), DEPTH);
      end
      for (int k = 0; k < got_pc.size(); k++) begin
         n_checks++;
         if (got_pc[k] !== RESET_PC + 64'(k) * 64'd4 || got_instr[k] !== fetch_word(RESET_PC + 64'(k) * 64'd4)) begin
            n_errors++;
            $display("FAIL bp_order[%0d]: pc=%h instr=%h required pc %h", k, got_pc[k], got_instr[k], RESET_PC + 64'(k) * 64'd4);
         end
      end
   endtask

   task automatic test_redirect();
      int t;
      mem.delete();
      apply_reset();
      id_ready = 1'b0;
      repeat (4) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h3000;
      id_ready       = 1'b1;
      #1;
      n_checks++;
      if (mem_rd_en !== 1'b0) begin
         n_errors++;
         $display("FAIL redir_no_issue: en=%b required 0", mem_rd_en);
      end
      tick();
      redirect_valid = 1'b0;
      clear_obs();
      t = cyc;
      repeat (10) tick();
      n_checks++;
      if (iss_addr.size() == 0 || iss_addr[0] !== 64'h3000 || iss_cyc[0] != t) begin
         n_errors++;
         $display("FAIL redir_issue: %0d issues, first not 3000 in cycle after redirect", iss_addr.size());
      end
      n_checks++;
      if (got_pc.size() == 0) begin
         n_errors++;
         $display("FAIL redir_deliver: got 0 transfers required some");
      end
      for (int k = 0; k < got_pc.size(); k++) begin
         n_checks++;
         if (got_pc[k] !== 64'h3000 + 64'(k) * 64'd4) begin
            n_errors++;
            $display("FAIL redir_order[%0d]: pc=%h required %h", k, got_pc[k], 64'h3000 + 64'(k) * 64'd4);
         end
      end
   endtask

   task automatic test_halt();
      logic h2004;
      logic h2008;
      int   bad_issue;
      mem.delete();
      mem[64'h2004] = 32'h7800_0001;
      mem[64'h2008] = 32'h7800_0000;
      apply_reset();
      id_ready  = 1'b1;
      h2004     = 1'bx;
      h2008     = 1'bx;
      bad_issue = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (if_valid && if_pc == 64'h2004) h2004 = halted;
         if (if_valid && if_pc == 64'h2008) h2008 = halted;
         if (halted && mem_rd_en) bad_issue++;
         tick();
      end
      n_checks++;
      if (h2004 !== 1'b0 || h2008 !== 1'b1) begin
         n_errors++;
         $display("FAIL halt_timing: halted at 2004 head=%b at 2008 head=%b required 0/1", h2004, h2008);
      end
      n_checks++;
      if (bad_issue != 0) begin
         n_errors++;
         $display("FAIL halt_issue: %0d issues while halted required 0", bad_issue);
      end
      n_checks++;
      if (got_pc.size() != 3 || got_pc[2] !== 64'h2008 || got_instr[2] !== 32'h7800_0000) begin
         n_errors++;
         $display("FAIL halt_stream: %0d transfers, required 2000,2004,2008 ending with the halt word", got_pc.size());
      end
      redirect_valid = 1'b1;
      redirect_pc    = 64'h2000;
      tick();
      redirect_valid = 1'b0;
      #1;
      n_checks++;
      if (halted !== 1'b0 || mem_rd_en !== 1'b1 || mem_rd_addr !== 64'h2000) begin
         n_errors++;
         $display("FAIL halt_resume: halted=%b en=%b addr=%h required 0/1/2000", halted, mem_rd_en, mem_rd_addr);
      end
   endtask

   task automatic test_fault();
      mem.delete();
      apply_reset();
      id_ready = 1'b1;
      repeat (4) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h3002;
      #1;
      n_checks++;
      if (mem_rd_en !== 1'b0) begin
         n_errors++;
         $display("FAIL fault_redir_issue: en=%b required 0", mem_rd_en);
      end
      tick();
      redirect_valid = 1'b0;
      clear_obs();
      repeat (5) tick();
      #1;
      n_checks++;
      if (fetch_fault !== 1'b1 || if_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL fault_set: fault=%b valid=%b required 1/0", fetch_fault, if_valid);
      end
      n_checks++;
      if (iss_addr.size() != 0 || got_pc.size() != 0) begin
         n_errors++;
         $display("FAIL fault_quiet: %0d issues %0d transfers required 0/0", iss_addr.size(), got_pc.size());
      end
      redirect_valid = 1'b1;
      redirect_pc    = 64'h3004;
      tick();
      redirect_valid = 1'b0;
      #1;
      n_checks++;
      if (fetch_fault !== 1'b0 || mem_rd_en !== 1'b1 || mem_rd_addr !== 64'h3004) begin
         n_errors++;
         $display("FAIL fault_clear: fault=%b en=%b addr=%h required 0/1/3004", fetch_fault, mem_rd_en, mem_rd_addr);
      end
      clear_obs();
      repeat (4) tick();
      n_checks++;
      if (got_pc.size() == 0 || got_pc[0] !== 64'h3004) begin
         n_errors++;
         $display("FAIL fault_resume: %0d transfers, first required pc 3004", got_pc.size());
      end
   endtask

   task automatic test_wrap();
      logic [63:0] base;
      base = 64'hFFFF_FFFF_FFFF_FFF8;
      mem.delete();
      apply_reset();
      id_ready       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = base;
      tick();
      redirect_valid = 1'b0;
      clear_obs();
      repeat (8) tick();
      n_checks++;
      if (got_pc.size() < 4) begin
         n_errors++;
         $display("FAIL wrap_count: got %0d transfers required at least 4", got_pc.size());
      end
      for (int k = 0; k < got_pc.size() && k < 4; k++) begin
         n_checks++;
         if (got_pc[k] !== base + 64'(k) * 64'd4) begin
            n_errors++;
            $display("FAIL wrap_pc[%0d]: pc=%h required %h", k, got_pc[k], base + 64'(k) * 64'd4);
         end
      end
   endtask

   task automatic test_async_reset();
      mem.delete();
      apply_reset();
      id_ready = 1'b0;
      repeat (6) tick();
      #1;
      n_checks++;
      if (if_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL areset_pre: valid=%b required 1", if_valid);
      end
      #1;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({if_valid, mem_rd_en, halted, fetch_fault} !== 4'b0000 || if_instr !== 32'h0 || if_pc !== 64'h0 || mem_rd_addr !== RESET_PC) begin
         n_errors++;
         $display("FAIL areset_out: valid/en/halted/fault=%b instr=%h pc=%h addr=%h required all reset values",
                  {if_valid, mem_rd_en, halted, fetch_fault}, if_instr, if_pc, mem_rd_addr);
      end
      @(negedge clk);
      reset    = 1'b1;
      id_ready = 1'b1;
      clear_obs();
      cyc = 0;
      repeat (5) tick();
      n_checks++;
      if (iss_addr.size() == 0 || iss_addr[0] !== RESET_PC || iss_cyc[0] != 0 ||
          got_pc.size() == 0 || got_pc[0] !== RESET_PC || got_cyc[0] != 2) begin
         n_errors++;
         $display("FAIL areset_restart: %0d issues %0d transfers, required restart at %h", iss_addr.size(), got_pc.size(), RESET_PC);
      end
   endtask

   task automatic test_random();
      logic [63:0] exp_pc;
      logic [63:0] exp_iss;
      logic [63:0] tgt;
      logic [63:0] a;
      logic [31:0] w;
      int          pend;
      mem.delete();
      apply_reset();
      exp_pc  = RESET_PC;
      exp_iss = RESET_PC;
      pend    = 0;
      for (int c = 0; c < 400; c++) begin
         id_ready       = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 24) == 0);
         tgt            = 64'h4000 + 64'($urandom_range(0, 1023)) * 64'd4;
         redirect_pc    = tgt;
         tick();
         while (iss_addr.size() > 0) begin
            a = iss_addr.pop_front();
            void'(iss_cyc.pop_front());
            n_checks++;
            if (redirect_valid || a !== exp_iss) begin
               n_errors++;
               $display("FAIL rand_issue: addr=%h redirect=%b required addr %h and no redirect", a, redirect_valid, exp_iss);
            end
            exp_iss = exp_iss + 64'd4;
            pend++;
         end
         while (got_pc.size() > 0) begin
            a = got_pc.pop_front();
            w = got_instr.pop_front();
            void'(got_cyc.pop_front());
            n_checks++;
            if (a !== exp_pc || w !== fetch_word(exp_pc)) begin
               n_errors++;
               $display("FAIL rand_deliver: pc=%h instr=%h required pc %h instr %h", a, w, exp_pc, fetch_word(exp_pc));
            end
            exp_pc = exp_pc + 64'd4;
            pend--;
         end
         n_checks++;
         if (pend > DEPTH || pend < 0) begin
            n_errors++;
            $display("FAIL rand_occupancy: %0d words outstanding required 0..%0d", pend, DEPTH);
         end
         if (redirect_valid) begin
            exp_pc  = tgt;
            exp_iss = tgt;
            pend    = 0;
         end
      end
      redirect_valid = 1'b0;
      id_ready       = 1'b1;
      repeat (6) tick();
      clear_obs();
      repeat (4) tick();
      n_checks++;
      if (got_pc.size() != 4) begin
         n_errors++;
         $display("FAIL rand_throughput: got %0d transfers in 4 cycles required 4", got_pc.size());
      end
      for (int k = 1; k < got_pc.size(); k++) begin
         n_checks++;
         if (got_pc[k] !== got_pc[k-1] + 64'd4) begin
            n_errors++;
            $display("FAIL rand_tail[%0d]: pc=%h required %h", k, got_pc[k], got_pc[k-1] + 64'd4);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect();
      test_halt();
      test_fault();
      test_wrap();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
